// File: rtl/calc_seq_pkg.sv
// Shared widths, opcodes and FSM encodings for calc_sequencer.
// Opcode 011 decodes as MUL only when CALC_SEQ_MUL_EN is defined.
package calc_seq_pkg;

   localparam int W  = 8;
   localparam int NW = 4;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_SHL1 = 3'b010;
   localparam logic [2:0] OP_MUL  = 3'b011;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LO   = 3'd1,
      S_HI   = 3'd2,
      S_SH   = 3'd3,
      S_MLO  = 3'd4,
      S_MHI  = 3'd5,
      S_DONE = 3'd6
   } state_t;

   function automatic logic op_reserved(input logic [2:0] op);
      logic r;
      case (op)
         OP_ADD, OP_SUB, OP_SHL1: r = 1'b0;
`ifdef CALC_SEQ_MUL_EN
         OP_MUL:                  r = 1'b0;
`endif
         default:                 r = 1'b1;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/calc_seq_nibble.sv
// 4-bit ripple-carry adder shared by every pass of calc_sequencer.
module calc_seq_nibble
   import calc_seq_pkg::*;
(
   input  logic [NW-1:0] x,
   input  logic [NW-1:0] y,
   input  logic          cin,
   output logic [NW-1:0] sum,
   output logic          cout
);

   logic [NW:0] cy;

   assign cy[0] = cin;

   for (genvar i = 0; i < NW; i++) begin : g_fa
      assign sum[i]  = x[i] ^ y[i] ^ cy[i];
      assign cy[i+1] = (x[i] & y[i]) | (cy[i] & (x[i] ^ y[i]));
   end

   assign cout = cy[NW];

endmodule

// File: rtl/calc_sequencer.sv
// Multi-cycle 8-bit calculator sequencing ADD/SUB/SHL1(/MUL) through one nibble adder.
// MUL (opcode 011) is built only when CALC_SEQ_MUL_EN is defined; otherwise it is reserved.
module calc_sequencer
   import calc_seq_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [2:0]   op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] y,
   output logic         c,
   output logic         of,
   output logic         err
);

   state_t         state_q, state_d;
   logic [W-1:0]   a_q, a_d, b_q, b_d, acc_q, acc_d, y_q, y_d;
   logic [2:0]     op_q, op_d;
   logic           carry_q, carry_d, c_q, c_d, of_q, of_d, err_q, err_d;
   logic [NW-1:0]  nib_x, nib_y, nib_sum;
   logic           nib_cin, nib_cout;
   logic           is_sub;
   logic [W-1:0]   b_eff;
`ifdef CALC_SEQ_MUL_EN
   logic [W-1:0]   m_q, m_d, q_q, q_d, addend;
   logic [2:0]     cnt_q, cnt_d;
   logic           ovf_q, ovf_d, lost_q, lost_d, mul_ovf;
`endif

   calc_seq_nibble u_nibble (
      .x    (nib_x),
      .y    (nib_y),
      .cin  (nib_cin),
      .sum  (nib_sum),
      .cout (nib_cout)
   );

   // SUB reuses the ADD passes: invert B here and inject cin=1 in the low pass.
   assign is_sub = (op_q == OP_SUB);
   assign b_eff  = is_sub ? ~b_q : b_q;
`ifdef CALC_SEQ_MUL_EN
   assign addend  = q_q[0] ? m_q : {W{1'b0}};
   assign mul_ovf = ovf_q | nib_cout | (q_q[0] & lost_q);
`endif

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               case (op)
                  OP_ADD, OP_SUB: state_d = S_LO;
                  OP_SHL1:        state_d = S_SH;
`ifdef CALC_SEQ_MUL_EN
                  OP_MUL:         state_d = S_MLO;
`endif
                  default:        state_d = S_DONE;
               endcase
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LO:   state_d = S_HI;
         S_HI:   state_d = S_DONE;
         S_SH:   state_d = S_DONE;
`ifdef CALC_SEQ_MUL_EN
         S_MLO:  state_d = S_MHI;
         S_MHI: begin
            if (cnt_q == 3'd7) state_d = S_DONE;
            else               state_d = S_MLO;
         end
`endif
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath and result-register loads per state
   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      acc_d   = acc_q;
      carry_d = carry_q;
      y_d     = y_q;
      c_d     = c_q;
      of_d    = of_q;
      err_d   = err_q;
      nib_x   = acc_q[NW-1:0];
      nib_y   = {NW{1'b0}};
      nib_cin = 1'b0;
`ifdef CALC_SEQ_MUL_EN
      m_d     = m_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      lost_d  = lost_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               op_d    = op;
               acc_d   = {W{1'b0}};
               carry_d = 1'b0;
`ifdef CALC_SEQ_MUL_EN
               m_d     = a;
               q_d     = b;
               cnt_d   = 3'd0;
               ovf_d   = 1'b0;
               lost_d  = 1'b0;
`endif
               if (op_reserved(op)) begin
                  y_d   = {W{1'b0}};
                  c_d   = 1'b0;
                  of_d  = 1'b0;
                  err_d = 1'b1;
               end else begin
                  err_d = err_q;
               end
            end else begin
               a_d = a_q;
            end
         end
         S_LO: begin
            nib_x            = a_q[NW-1:0];
            nib_y            = b_eff[NW-1:0];
            nib_cin          = is_sub;
            acc_d[NW-1:0]    = nib_sum;
            carry_d          = nib_cout;
         end
         S_HI: begin
            nib_x            = a_q[W-1:NW];
            nib_y            = b_eff[W-1:NW];
            nib_cin          = carry_q;
            acc_d[W-1:NW]    = nib_sum;
            y_d              = {nib_sum, acc_q[NW-1:0]};
            c_d              = nib_cout;
            of_d             = (a_q[W-1] == b_eff[W-1]) && (nib_sum[NW-1] != a_q[W-1]);
            err_d            = 1'b0;
         end
         S_SH: begin
            y_d   = {a_q[W-2:0], 1'b0};
            c_d   = a_q[W-1];
            of_d  = a_q[W-1] ^ a_q[W-2];
            err_d = 1'b0;
         end
`ifdef CALC_SEQ_MUL_EN
         S_MLO: begin
            nib_x         = acc_q[NW-1:0];
            nib_y         = addend[NW-1:0];
            nib_cin       = 1'b0;
            acc_d[NW-1:0] = nib_sum;
            carry_d       = nib_cout;
         end
         S_MHI: begin
            nib_x         = acc_q[W-1:NW];
            nib_y         = addend[W-1:NW];
            nib_cin       = carry_q;
            acc_d[W-1:NW] = nib_sum;
            ovf_d         = mul_ovf;
            lost_d        = lost_q | m_q[W-1];
            m_d           = {m_q[W-2:0], 1'b0};
            q_d           = {1'b0, q_q[W-1:1]};
            cnt_d         = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               y_d   = {nib_sum, acc_q[NW-1:0]};
               c_d   = mul_ovf;
               of_d  = mul_ovf;
               err_d = 1'b0;
            end else begin
               y_d   = y_q;
            end
         end
`endif
         default: begin
            nib_cin = 1'b0;
         end
      endcase
   end

   // Operand, accumulator and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= {W{1'b0}};
         b_q     <= {W{1'b0}};
         op_q    <= 3'd0;
         acc_q   <= {W{1'b0}};
         carry_q <= 1'b0;
         y_q     <= {W{1'b0}};
         c_q     <= 1'b0;
         of_q    <= 1'b0;
         err_q   <= 1'b0;
`ifdef CALC_SEQ_MUL_EN
         m_q     <= {W{1'b0}};
         q_q     <= {W{1'b0}};
         cnt_q   <= 3'd0;
         ovf_q   <= 1'b0;
         lost_q  <= 1'b0;
`endif
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         acc_q   <= acc_d;
         carry_q <= carry_d;
         y_q     <= y_d;
         c_q     <= c_d;
         of_q    <= of_d;
         err_q   <= err_d;
`ifdef CALC_SEQ_MUL_EN
         m_q     <= m_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         lost_q  <= lost_d;
`endif
      end
   end

   assign busy = (state_q != S_IDLE);
   assign done = (state_q == S_DONE);
   assign y    = y_q;
   assign c    = c_q;
   assign of   = of_q;
   assign err  = err_q;

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Multi-cycle controller that sequences an 8-bit calculator operation through a single shared 4-bit nibble adder and a 1-bit left shifter.
- Accepts an operation request, latches operands, then runs low-nibble and high-nibble adder passes (shift-add loop for multiply).
- Reports result, carry and overflow with a one-cycle `done` pulse.
- Sits between the calculator's operand/opcode inputs and its result outputs, replacing a full-width combinational datapath.

## Interface
Parameters: none (width fixed at 8 bits, nibble 4 bits).

Clock, reset and single clock domain (decided):
- `clk  in  1` — single clock, rising edge.
- `rst  in  1` — synchronous, active-high reset.

Request and operands:
- `start  in  1` — request; accepted only in IDLE.
- `op  in  3` — opcode, sampled with `start`.
- `a  in  8` — operand A, sampled with `start`.
- `b  in  8` — operand B, sampled with `start`.

Status and results:
- `busy  out  1` — state != IDLE.
- `done  out  1` — one-cycle pulse; results valid.
- `y  out  8` — result.
- `c  out  1` — carry / no-borrow / shifted-out bit.
- `of  out  1` — overflow.
- `err  out  1` — reserved opcode executed.

## Operation
- Opcodes:
  - 000 ADD
  - 001 SUB
  - 010 SHL1
  - 011 MUL (low 8 bits)
  - 1xx reserved
- States: IDLE, LO, HI, SH, MLO, MHI, DONE.
- IDLE & `start`: latch `a`, `b`, `op`, then go to:
  - ADD/SUB → LO
  - SHL1 → SH
  - MUL → MLO
  - reserved → DONE
- ADD: LO computes `a[3:0]+b[3:0]+0` into acc[3:0] and a carry register; HI computes `a[7:4]+b[7:4]+carry`.
  - `c` = final carry.
  - `of` = (a7==b7)&&(y7!=a7).
- SUB: same passes with `b` inverted and cin=1.
  - `c` = 1 means no borrow.
  - `of` uses inverted b7.
- SHL1: `y = {a[6:0],0}`, `c = a[7]`, `of = a7^a6`.
- MUL: acc=0, m=a, q=b, iteration counter = 0..7.
  - Each iteration: MLO then MHI add `(q[0] ? m : 0)` into acc.
  - After MHI: m<<=1, q>>=1, counter++.
  - After iteration 7 MHI → DONE.
  - Sticky `ovf`: set on any MHI carry-out, or when q[0]=1 while `lost` is set. `lost` is a sticky flag set when m[7]=1 is shifted out.
  - `y` = acc, `of` = `c` = ovf.
- Reserved opcode: `y=0`, `c=0`, `of=0`, `err=1`.
- Non-reserved opcodes: `err=0`.
- DONE: `done=1` for exactly one cycle, then IDLE.
- Outputs `y`, `c`, `of`, `err` load only on the edge entering DONE and hold until the next DONE entry.

## Timing
- T = cycle with `start=1` in IDLE. `done` is asserted at:
  - ADD/SUB: T+3
  - SHL1: T+2
  - MUL: T+17 (fixed, data-independent)
  - reserved: T+1
- `busy` = 1 from T+1 through the DONE cycle inclusive; 0 otherwise.
- Earliest next accept: the cycle after DONE (back-to-back requests are 1 cycle apart after `done`).
- `start` while `busy`: ignored, not queued; latched operands and op unaffected.
- Operand/op inputs may change freely after T.
- Reset values:
  - state IDLE
  - `busy`, `done`, `y`, `c`, `of`, `err` all 0
  - internal acc/carry/counter/sticky flags 0
- `rst` wins over `start` in the same cycle.
- `rst` mid-operation: IDLE and all outputs 0 after that edge; no `done`.
- Arithmetic is modulo 2^8; no widening.

## Configuration
- `CALC_SEQ_MUL_EN` defined: opcode 011 is MUL as above; MLO/MHI states, m/q registers, counter and sticky flags are present.
- Not defined: opcode 011 is treated as reserved (DONE at T+1, `err=1`, `y=0`); MUL logic is compiled out.

## Structure
- Shared package `calc_seq_pkg`:
  - opcode constants (OP_ADD, OP_SUB, OP_SHL1, OP_MUL)
  - state encodings
  - widths W=8, NW=4
- Sub-module `calc_seq_nibble`: 4-bit ripple adder with `cin`/`cout`, instantiated once and shared by LO/HI/MLO/MHI.
- Operand muxing and B inversion stay in the top level.

## Test plan
- ADD a=0x7F b=0x01 → `done` at T+3, y=0x80, c=0, of=1, err=0; `busy` high T+1..T+3.
- SUB a=0x10 b=0x20 → y=0xF0, c=0, of=0; SUB a=0x80 b=0x01 → y=0x7F, c=1, of=1.
- SHL1 a=0xC3 → `done` at T+2, y=0x86, c=1, of=0.
- MUL a=0x0D b=0x0B → `done` at T+17, y=0x8F, of=0; MUL a=0x20 b=0x10 → y=0x00, c=1, of=1. Without `CALC_SEQ_MUL_EN`: op=011 → `done` at T+1, err=1, y=0.
- MUL accepted at T, `start` with ADD pulsed at T+4 → ignored, MUL result unchanged; separate run: `rst` at T+5 → busy=0, y=0 next cycle, no `done`.
- op=3'b101 a=0xFF b=0xFF → `done` at T+1, y=0x00, c=0, of=0, err=1; following ADD 0x01+0x01 → y=0x02, err=0.
